// File: rtl/gstdmasnd_addr_if.sv
// Bus bundle between the CPU/shifter side and the DMA-sound frame sequencer.
// master drives register access and fetch-slot requests; slave is the sequencer.
interface gstdmasnd_addr_if #(
  parameter int ADDR_W = 23
);
  logic              CS;
  logic [5:0]        A;
  logic [15:0]       DIN;
  logic              RW;
  logic [15:0]       DOUT;
  logic              SREQ;
  logic              SLOT;
  logic              SLOAD_N;
  logic [ADDR_W-1:0] SADDR;
  logic              SINT;
  logic              PLAYING;

  modport master (
    output CS, A, DIN, RW, SREQ, SLOT,
    input  DOUT, SLOAD_N, SADDR, SINT, PLAYING
  );

  modport slave (
    input  CS, A, DIN, RW, SREQ, SLOT,
    output DOUT, SLOAD_N, SADDR, SINT, PLAYING
  );
endinterface

// File: rtl/gstdmasnd_addr.sv
// STE DMA-sound frame sequencer: start/end/counter registers, slot arbitration, 4-cycle SLOAD_N fetch.
// Optional GSTDMASND_CNTR_READ_EN exposes the live frame counter at offsets 0x04-0x06.
module gstdmasnd_addr #(
  parameter int ADDR_W = 23
) (
  input  logic                   clk32,
  input  logic                   resb,
  gstdmasnd_addr_if.slave        bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        r_fcnt;
  logic              r_cs_d;
  logic [1:0]        r_ctrl;
  logic [ADDR_W-1:0] r_start;
  logic [ADDR_W-1:0] r_endr;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_end_l;
  logic              r_sload_n;
  logic              r_sint;

  logic              w_wr;
  logic              w_ctrl_wr;
  logic              w_stop;
  logic              w_eof;
  logic [15:0]       w_dout;
  logic              w_unused;

  assign w_wr      = r_cs_d & ~bus.CS & ~bus.RW;
  assign w_ctrl_wr = w_wr & (bus.A == 6'h00);
  assign w_stop    = w_ctrl_wr & ~bus.DIN[0];
  assign w_eof     = (r_cnt == r_end_l);
  assign w_unused  = ^bus.DIN[15:8];

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_cs_d <= 1'b0;
    end else begin
      r_cs_d <= bus.CS;
    end
  end

  // Start/end writes only touch the CPU copies; the running frame uses the latches.
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_start <= '0;
      r_endr  <= '0;
    end else if (w_wr) begin
      case (bus.A)
        6'h01:   r_start[22:15] <= bus.DIN[7:0];
        6'h02:   r_start[14:7]  <= bus.DIN[7:0];
        6'h03:   r_start[6:0]   <= bus.DIN[7:1];
        6'h07:   r_endr[22:15]  <= bus.DIN[7:0];
        6'h08:   r_endr[14:7]   <= bus.DIN[7:0];
        6'h09:   r_endr[6:0]    <= bus.DIN[7:1];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_state   <= ST_IDLE;
      r_fcnt    <= 2'd0;
      r_ctrl    <= 2'b00;
      r_cnt     <= '0;
      r_end_l   <= '0;
      r_sload_n <= 1'b1;
      r_sint    <= 1'b0;
    end else begin
      r_sint <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ctrl_wr) begin
            r_ctrl <= bus.DIN[1:0];
            if (bus.DIN[0]) begin
              r_state <= ST_PLAY;
              r_cnt   <= r_start;
              r_end_l <= r_endr;
            end
          end
        end
        ST_PLAY: begin
          if (w_stop) begin
            r_ctrl  <= {bus.DIN[1], 1'b0};
            r_state <= ST_IDLE;
          end else begin
            if (w_ctrl_wr) begin
              r_ctrl[1] <= bus.DIN[1];
            end
            if (bus.SLOT) begin
              if (w_eof) begin
                r_sint <= 1'b1;
                if (r_ctrl[1]) begin
                  r_cnt   <= r_start;
                  r_end_l <= r_endr;
                end else begin
                  r_ctrl[0] <= 1'b0;
                  r_state   <= ST_IDLE;
                end
              end else if (bus.SREQ) begin
                r_state   <= ST_FETCH;
                r_fcnt    <= 2'd0;
                r_sload_n <= 1'b0;
              end
            end
          end
        end
        ST_FETCH: begin
          if (w_ctrl_wr) begin
            r_ctrl[1] <= bus.DIN[1];
            if (!bus.DIN[0]) begin
              r_ctrl[0] <= 1'b0;
            end
          end
          // A stop requested mid-fetch lets the strobe run its full length first.
          if (r_fcnt == 2'd3) begin
            r_sload_n <= 1'b1;
            r_cnt     <= r_cnt + 1'b1;
            r_state   <= (r_ctrl[0] && !w_stop) ? ST_PLAY : ST_IDLE;
          end else begin
            r_fcnt <= r_fcnt + 2'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_dout = 16'h0000;
    if (bus.CS && bus.RW) begin
      case (bus.A)
        6'h00:   w_dout = {14'd0, r_ctrl};
        6'h01:   w_dout = {8'd0, r_start[22:15]};
        6'h02:   w_dout = {8'd0, r_start[14:7]};
        6'h03:   w_dout = {8'd0, r_start[6:0], 1'b0};
`ifdef GSTDMASND_CNTR_READ_EN
        6'h04:   w_dout = {8'd0, r_cnt[22:15]};
        6'h05:   w_dout = {8'd0, r_cnt[14:7]};
        6'h06:   w_dout = {8'd0, r_cnt[6:0], 1'b0};
`else
        6'h04:   w_dout = 16'h0000;
        6'h05:   w_dout = 16'h0000;
        6'h06:   w_dout = 16'h0000;
`endif
        6'h07:   w_dout = {8'd0, r_endr[22:15]};
        6'h08:   w_dout = {8'd0, r_endr[14:7]};
        6'h09:   w_dout = {8'd0, r_endr[6:0], 1'b0};
        default: w_dout = 16'h0000;
      endcase
    end
  end

  assign bus.DOUT    = w_dout;
  assign bus.SLOAD_N = r_sload_n;
  assign bus.SADDR   = r_cnt;
  assign bus.SINT    = r_sint;
  assign bus.PLAYING = (r_state != ST_IDLE);

endmodule

// File: doc/gstdmasnd_addr.md
# gstdmasnd_addr

STE DMA-sound frame sequencer sitting directly upstream of the shifter's audio FIFO. It holds the CPU-visible frame start/end/counter registers, arbitrates sound fetch slots against the shifter's `SREQ`, and drives `SLOAD_N` and the word address so that each fetched RAM word lands in the shifter FIFO. It signals end-of-frame and handles one-shot and repeat playback.

## Interface
Parameters:
- `ADDR_W`, 23: word-address width (byte address bits 23:1).

Ports:
- `clk32`, in, 1: 32 MHz system clock.
- `resb`, in, 1: reset. Asynchronous, active-low.
- `CS`, in, 1: register select for the `$FF8900` block.
- `A`, in, 6: word offset, `A[6:1]`.
- `DIN`, in, 16: CPU write data.
- `RW`, in, 1: 1 = read.
- `DOUT`, out, 16: register read data. Combinational. 0 when not (`CS & RW`).
- `SREQ`, in, 1: shifter FIFO not full.
- `SLOT`, in, 1: one-`clk32` strobe marking a sound-fetch bus slot.
- `SLOAD_N`, out, 1: fetch strobe to the shifter. Active low.
- `SADDR`, out, `ADDR_W`: RAM word address. Valid while `SLOAD_N` = 0.
- `SINT`, out, 1: end-of-frame pulse, one `clk32` cycle.
- `PLAYING`, out, 1: state ≠ IDLE.

## Operation
Registers are decoded by `A`. Byte registers occupy `DOUT[7:0]`; all other bits read 0.
- `0x00` ctrl: bit0 = play, bit1 = repeat. Read/write.
- `0x01`/`0x02`/`0x03`: frame start, bits 23:16, 15:8 and 7:1. Bit0 always reads 0.
- `0x04`/`0x05`/`0x06`: frame counter. Read-only; writes are ignored.
- `0x07`/`0x08`/`0x09`: frame end, same layout as frame start.

Write timing:
- A write commits on the `CS` falling edge with `RW` = 0 (registered `CS_d & ~CS & ~RW`), using `DIN`.

Latches:
- `cnt` and `end_l` are internal 23-bit latches, loaded from start/end on frame (re)start.
- Writes to start/end never disturb a running frame.

States: IDLE, PLAY, FETCH.
- IDLE → PLAY: ctrl write with bit0 = 1. Same cycle: `cnt` ← start, `end_l` ← end.
- PLAY, `SLOT` = 1, `cnt` ≠ `end_l`, `SREQ` = 1 → FETCH.
- PLAY, `SLOT` = 1, `SREQ` = 0 → no action (slot lost).
- PLAY, `SLOT` = 1, `cnt` == `end_l` (end-of-frame) → `SINT` pulses.
  - If repeat: reload `cnt`/`end_l` from the registers and stay in PLAY.
  - Otherwise: clear ctrl bit0 and go to IDLE.
- FETCH: `SLOAD_N` low for exactly 4 cycles with `SADDR` = `cnt`. On exit, `cnt` ← `cnt` + 1 and return to PLAY.
- ctrl write with bit0 = 0:
  - From PLAY: go to IDLE next cycle.
  - During FETCH: the fetch completes (no truncated strobe), then IDLE. No `SINT`.
- ctrl write with bit0 = 1 while not IDLE: only the repeat bit updates; there is no restart.

Arithmetic and boundaries:
- `cnt` wraps modulo 2^23.
- start == end: an empty frame. The first slot produces the end-of-frame event with no fetch.
- start > end: fetches run through the wrap until `cnt` == `end_l`.
- `SLOT` arriving during FETCH is ignored.

Reset values:
- `SLOAD_N` = 1, `SADDR` = 0, `SINT` = 0, `PLAYING` = 0.
- All registers and latches = 0. State = IDLE.
- Reset asserted mid-FETCH forces `SLOAD_N` high immediately (asynchronous).

## Timing
- Slot sampled at edge N → `SLOAD_N` falls at N+1 and rises at N+5. `cnt` increments at N+5.
- The shifter captures data on the `SLOAD_N` falling edge. `SADDR` is stable from N+1 to N+5.
- End-of-frame slot at edge N → `SINT` high for cycle N+1 only. `PLAYING` falls at N+1 (non-repeat).
- Counter readback reflects `cnt` combinationally. The value is post-increment from N+5.
- The minimum spacing between fetches is one slot; a `SLOT` at N+5 or later is honoured.

## Configuration
- `GSTDMASND_CNTR_READ_EN` defined: offsets `0x04`–`0x06` return live `cnt` bytes.
- `GSTDMASND_CNTR_READ_EN` undefined: offsets `0x04`–`0x06` read 0, and the counter readback mux is not synthesized. Sequencing is unaffected.

## Test plan
- **Normal one-shot frame.**
  - Stimulus: start = `0x010000`, end = `0x010008`, repeat = 0, play; `SREQ` = 1; `SLOT` every 64 cycles.
  - Response: 4 fetches at `SADDR` = `0x008000`..`0x008003`, each `SLOAD_N` low for 4 cycles; then `SINT` for 1 cycle and `PLAYING` = 0; ctrl reads `0x0000`.
- **Repeat mode.**
  - Stimulus: start = `0x020000`, end = `0x020004`, repeat = 1; 8 slots.
  - Response: addresses `0x010000`, `0x010001`, then end-of-frame (`SINT`), then `0x010000`, `0x010001` again; `PLAYING` stays 1.
- **Back-pressure.**
  - Stimulus: `SREQ` = 0 for 3 slots mid-frame.
  - Response: no `SLOAD_N` activity and `cnt` unchanged; the fetch resumes at the same address when `SREQ` returns to 1.
- **Stop during FETCH and empty frame.**
  - Stimulus: ctrl ← 0 at N+2 of a fetch.
  - Response: `SLOAD_N` still rises at N+5, `cnt` increments, IDLE follows, no `SINT`.
  - Stimulus: start = end = `0x030000`, play.
  - Response: first slot gives `SINT` with zero fetches.
- **Reset mid-fetch and counter readback.**
  - Stimulus: `resb` low at N+2.
  - Response: `SLOAD_N` = 1 the same cycle and all reads return 0.
  - With `GSTDMASND_CNTR_READ_EN`: reading `0x06` after 3 fetches from `0x010000` returns `0x0006`.
  - Without `GSTDMASND_CNTR_READ_EN`: the same read returns `0x0000`.
